// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte from the host to a PS/2 device.
// Does request-to-send, shifts data on device clock falling edges,
// appends odd parity and stop, checks the device ack and runs a watchdog.
// Both PS/2 lines are only ever pulled low or released.
module ps2_host_tx #(
   parameter int INHIBIT_CYC = 10000,
   parameter int TIMEOUT_CYC = 2000000,
   parameter int FILT_LEN    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_ps2,
   input  logic [7:0] din,
   inout  wire        ps2c,
   inout  wire        ps2d,
   output logic       tx_idle,
   output logic       tx_done_tick,
   output logic       ack_err,
   output logic       timeout_tick
);

   localparam int CNT_W = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;
   localparam int WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RTS,
      S_START,
      S_DATA,
      S_STOP,
      S_ACK,
      S_DONE
   } state_t;

   state_t             r_state;
   state_t             w_stateNext;
   logic [FILT_LEN-1:0] r_filtSr;
   logic               r_filtLvl;
   logic [1:0]         r_dSync;
   logic [8:0]         r_b;
   logic [3:0]         r_n;
   logic [CNT_W-1:0]   r_cnt;
   logic [WD_W-1:0]    r_wd;
   logic               r_cLow;
   logic               r_dLow;
   logic               r_txIdle;
   logic               r_doneTick;
   logic               r_ackErr;
   logic               r_toTick;

   logic               w_filtNext;
   logic               w_fallEdge;
   logic [8:0]         w_bNext;
   logic [3:0]         w_nNext;
   logic [CNT_W-1:0]   w_cntNext;
   logic [WD_W-1:0]    w_wdNext;
   logic               w_doneNext;
   logic               w_errNext;
   logic               w_toNext;
   logic               w_cLowNext;
   logic               w_dLowNext;

   // Open-drain drive: pull low or float, never drive high.
   assign ps2c = r_cLow ? 1'b0 : 1'bz;
   assign ps2d = r_dLow ? 1'b0 : 1'bz;

   assign tx_idle      = r_txIdle;
   assign tx_done_tick = r_doneTick;
   assign ack_err      = r_ackErr;
   assign timeout_tick = r_toTick;

   // Filtered clock only changes once every sample in the window agrees.
   assign w_filtNext = (&r_filtSr) ? 1'b1 : ((|r_filtSr) ? r_filtLvl : 1'b0);
   assign w_fallEdge = r_filtLvl & ~w_filtNext;

   // Sample the device clock into the glitch filter and synchronize the data line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_filtSr  <= '1;
         r_filtLvl <= 1'b1;
         r_dSync   <= 2'b11;
      end else begin
         r_filtSr  <= {r_filtSr[FILT_LEN-2:0], ps2c};
         r_filtLvl <= w_filtNext;
         r_dSync   <= {r_dSync[0], ps2d};
      end
   end

   // Next-state, datapath and registered line/tick values for the frame sequencer.
   always_comb begin
      w_stateNext = r_state;
      w_bNext     = r_b;
      w_nNext     = r_n;
      w_cntNext   = r_cnt;
      w_wdNext    = '0;
      w_doneNext  = 1'b0;
      w_errNext   = 1'b0;
      w_toNext    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (wr_ps2) begin
               w_stateNext = S_RTS;
               w_bNext     = {~^din, din};
               w_cntNext   = CNT_W'(INHIBIT_CYC - 1);
            end
         end
         S_RTS: begin
            if (r_cnt == '0) begin
               w_stateNext = S_START;
            end else begin
               w_cntNext = r_cnt - 1'b1;
            end
         end
         S_START: begin
            if (w_fallEdge) begin
               w_stateNext = S_DATA;
               w_nNext     = 4'd8;
            end
         end
         S_DATA: begin
            if (w_fallEdge) begin
               w_bNext = {1'b1, r_b[8:1]};
               if (r_n == 4'd0) begin
                  w_stateNext = S_STOP;
               end else begin
                  w_nNext = r_n - 4'd1;
               end
            end
         end
         S_STOP: begin
            if (w_fallEdge) begin
               w_stateNext = S_ACK;
            end
         end
         S_ACK: begin
            if (w_fallEdge) begin
               w_stateNext = S_DONE;
               if (r_dSync[1] == 1'b0) begin
                  w_doneNext = 1'b1;
               end else begin
                  w_errNext = 1'b1;
               end
            end
         end
         S_DONE: begin
            w_stateNext = S_IDLE;
         end
         default: begin
            w_stateNext = S_IDLE;
         end
      endcase
      if (r_state inside {S_START, S_DATA, S_STOP, S_ACK}) begin
         if (w_fallEdge || (w_stateNext != r_state)) begin
            w_wdNext = '0;
         end else if (r_wd == WD_W'(TIMEOUT_CYC - 1)) begin
            w_toNext    = 1'b1;
            w_stateNext = S_DONE;
         end else begin
            w_wdNext = r_wd + 1'b1;
         end
      end
      w_cLowNext = (w_stateNext == S_RTS);
      w_dLowNext = (w_stateNext == S_START) || ((w_stateNext == S_DATA) && !w_bNext[0]);
   end

   // Register state, datapath and every output so lines and ticks are glitch-free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_b        <= '0;
         r_n        <= '0;
         r_cnt      <= '0;
         r_wd       <= '0;
         r_cLow     <= 1'b0;
         r_dLow     <= 1'b0;
         r_txIdle   <= 1'b1;
         r_doneTick <= 1'b0;
         r_ackErr   <= 1'b0;
         r_toTick   <= 1'b0;
      end else begin
         r_state    <= w_stateNext;
         r_b        <= w_bNext;
         r_n        <= w_nNext;
         r_cnt      <= w_cntNext;
         r_wd       <= w_wdNext;
         r_cLow     <= w_cLowNext;
         r_dLow     <= w_dLowNext;
         r_txIdle   <= (w_stateNext == S_IDLE);
         r_doneTick <= w_doneNext;
         r_ackErr   <= w_errNext;
         r_toTick   <= w_toNext;
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: drives ps2_host_tx against a behavioural PS/2 device that
// clocks the frame, records the bits it sees and optionally acknowledges.
module tb_ps2_host_tx;

   localparam int INHIBIT = 1000;
   localparam int TIMEOUT = 5000;
   localparam int FILT    = 8;
   localparam int HALF    = 40;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_ps2 = 1'b0;
   logic [7:0] din = 8'h00;
   wire        ps2c;
   wire        ps2d;
   logic       tx_idle;
   logic       tx_done_tick;
   logic       ack_err;
   logic       timeout_tick;

   logic devClkLow = 1'b0;
   logic devDataLow = 1'b0;

   int checks = 0;
   int errors = 0;
   int doneCnt = 0;
   int errCnt = 0;
   int toCnt = 0;
   int overlapCnt = 0;

   assign ps2c = devClkLow ? 1'b0 : 1'bz;
   assign ps2d = devDataLow ? 1'b0 : 1'bz;
   pullup (ps2c);
   pullup (ps2d);

   ps2_host_tx #(
      .INHIBIT_CYC(INHIBIT),
      .TIMEOUT_CYC(TIMEOUT),
      .FILT_LEN(FILT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .wr_ps2(wr_ps2),
      .din(din),
      .ps2c(ps2c),
      .ps2d(ps2d),
      .tx_idle(tx_idle),
      .tx_done_tick(tx_done_tick),
      .ack_err(ack_err),
      .timeout_tick(timeout_tick)
   );

   // 100 MHz-style system clock.
   always #5 clk = ~clk;

   // Tally every tick pulse and any cycle where more than one is high.
   always @(negedge clk) begin
      if (tx_done_tick === 1'b1) doneCnt++;
      if (ack_err === 1'b1) errCnt++;
      if (timeout_tick === 1'b1) toCnt++;
      if ((int'(tx_done_tick) + int'(ack_err) + int'(timeout_tick)) > 1) overlapCnt++;
   end

   // Bits a device should see: start 0, data LSB first, odd parity, stop 1.
   function automatic logic [10:0] expected_frame(input logic [7:0] d);
      logic [10:0] f;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[i+1] = d[i];
      f[9] = (($countones(d) % 2) == 0);
      f[10] = 1'b1;
      return f;
   endfunction

   // Request a send and count how many cycles the host inhibits the clock.
   task automatic send_and_measure(input logic [7:0] d, output int lowCycles);
      int w;
      w = 0;
      while (tx_idle !== 1'b1 && w < 20000) begin
         @(negedge clk);
         w++;
      end
      din = d;
      wr_ps2 = 1'b1;
      @(negedge clk);
      wr_ps2 = 1'b0;
      din = 8'($urandom);
      lowCycles = 0;
      while (ps2c === 1'b0 && lowCycles < 3 * INHIBIT) begin
         lowCycles++;
         @(negedge clk);
      end
   endtask

   // Device side: waits for the start bit, then produces nFalls clock pulses.
   task automatic device_frame(input int nFalls, input bit giveAck, input bit glitch,
                               output logic [10:0] capt);
      int w;
      capt = '1;
      w = 0;
      while (!(ps2c === 1'b1 && ps2d === 1'b0) && w < 4 * INHIBIT) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (w >= 4 * INHIBIT) begin
         errors++;
         $display("[TB] FAIL device_start waited %0d cycles, required start bit within %0d", w, 4 * INHIBIT);
         return;
      end
      repeat (HALF) @(negedge clk);
      capt[0] = ps2d;
      repeat (HALF) @(negedge clk);
      for (int k = 1; k <= nFalls; k++) begin
         devClkLow = 1'b1;
         if (k == 11 && giveAck) devDataLow = 1'b1;
         repeat (HALF) @(negedge clk);
         devClkLow = 1'b0;
         if (k == 12) devDataLow = 1'b0;
         repeat (HALF / 2) @(negedge clk);
         if (k <= 10) capt[k] = ps2d;
         if (glitch && k >= 2 && k <= 8) begin
            devClkLow = 1'b1;
            repeat (3) @(negedge clk);
            devClkLow = 1'b0;
            repeat (HALF / 2 - 3) @(negedge clk);
         end else begin
            repeat (HALF / 2) @(negedge clk);
         end
      end
   endtask

   // One complete frame with the device either acknowledging or not.
   task automatic test_frame(input logic [7:0] d, input bit giveAck, input bit glitch);
      int low;
      int d0;
      int e0;
      int t0;
      logic [10:0] capt;
      logic [10:0] exp;
      d0 = doneCnt;
      e0 = errCnt;
      t0 = toCnt;
      exp = expected_frame(d);
      send_and_measure(d, low);
      checks++;
      if (low !== INHIBIT) begin
         errors++;
         $display("[TB] FAIL rts_low byte %02h got %0d cycles expected %0d", d, low, INHIBIT);
      end
      device_frame(12, giveAck, glitch, capt);
      repeat (2 * HALF) @(negedge clk);
      checks++;
      if (capt !== exp) begin
         errors++;
         $display("[TB] FAIL frame_bits byte %02h got %011b expected %011b", d, capt, exp);
      end
      checks++;
      if ((doneCnt - d0) !== (giveAck ? 1 : 0)) begin
         errors++;
         $display("[TB] FAIL done_count byte %02h got %0d expected %0d", d, doneCnt - d0, giveAck ? 1 : 0);
      end
      checks++;
      if ((errCnt - e0) !== (giveAck ? 0 : 1)) begin
         errors++;
         $display("[TB] FAIL ackerr_count byte %02h got %0d expected %0d", d, errCnt - e0, giveAck ? 0 : 1);
      end
      checks++;
      if ((toCnt - t0) !== 0) begin
         errors++;
         $display("[TB] FAIL timeout_count byte %02h got %0d expected 0", d, toCnt - t0);
      end
      checks++;
      if (tx_idle !== 1'b1) begin
         errors++;
         $display("[TB] FAIL idle_after byte %02h got %b expected 1", d, tx_idle);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (tx_idle !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_idle got %b expected 1", tx_idle);
      end
      checks++;
      if ({tx_done_tick, ack_err, timeout_tick} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL reset_ticks got %03b expected 000", {tx_done_tick, ack_err, timeout_tick});
      end
      checks++;
      if (ps2c !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_ps2c got %b expected 1", ps2c);
      end
      checks++;
      if (ps2d !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_ps2d got %b expected 1", ps2d);
      end
      rst = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (tx_idle !== 1'b1 || ps2c !== 1'b1) begin
         errors++;
         $display("[TB] FAIL post_reset_idle got idle=%b ps2c=%b expected 1 1", tx_idle, ps2c);
      end
   endtask

   task automatic test_parity();
      test_frame(8'h01, 1'b1, 1'b0);
      test_frame(8'hFF, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) test_frame(8'($urandom), 1'b1, 1'b0);
   endtask

   task automatic test_timeout();
      int low;
      int cnt;
      int d0;
      int e0;
      int t0;
      logic [10:0] capt;
      d0 = doneCnt;
      e0 = errCnt;
      t0 = toCnt;
      send_and_measure(8'($urandom), low);
      device_frame(4, 1'b0, 1'b0, capt);
      devClkLow = 1'b1;
      cnt = 0;
      while (timeout_tick !== 1'b1 && cnt < 2 * TIMEOUT) begin
         @(negedge clk);
         cnt++;
         if (cnt == HALF) devClkLow = 1'b0;
      end
      // The filter needs FILT agreeing samples plus one registered cycle to
      // recognise the edge; the watchdog then runs TIMEOUT cycles.
      checks++;
      if (cnt !== FILT + 1 + TIMEOUT) begin
         errors++;
         $display("[TB] FAIL timeout_delay got %0d cycles expected %0d", cnt, FILT + 1 + TIMEOUT);
      end
      checks++;
      if (ps2c !== 1'b1 || ps2d !== 1'b1) begin
         errors++;
         $display("[TB] FAIL timeout_release got ps2c=%b ps2d=%b expected 1 1", ps2c, ps2d);
      end
      repeat (3) @(negedge clk);
      checks++;
      if ((toCnt - t0) !== 1 || (doneCnt - d0) !== 0 || (errCnt - e0) !== 0) begin
         errors++;
         $display("[TB] FAIL timeout_ticks got to=%0d done=%0d err=%0d expected 1 0 0",
                  toCnt - t0, doneCnt - d0, errCnt - e0);
      end
      checks++;
      if (tx_idle !== 1'b1) begin
         errors++;
         $display("[TB] FAIL timeout_idle got %b expected 1", tx_idle);
      end
   endtask

   task automatic test_reset_mid_frame();
      int low;
      int tickSum;
      int d0;
      logic [10:0] capt;
      logic [7:0] d2;
      logic [7:0] d3;
      send_and_measure(8'($urandom), low);
      device_frame(4, 1'b0, 1'b0, capt);
      tickSum = doneCnt + errCnt + toCnt;
      rst = 1'b1;
      #1;
      checks++;
      if (ps2c !== 1'b1 || ps2d !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midreset_release got ps2c=%b ps2d=%b expected 1 1", ps2c, ps2d);
      end
      checks++;
      if (tx_idle !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midreset_idle got %b expected 1", tx_idle);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      checks++;
      if ((doneCnt + errCnt + toCnt) !== tickSum) begin
         errors++;
         $display("[TB] FAIL midreset_ticks got %0d new ticks expected 0", doneCnt + errCnt + toCnt - tickSum);
      end
      d0 = doneCnt;
      d2 = 8'($urandom);
      d3 = ~d2;
      din = d2;
      wr_ps2 = 1'b1;
      @(negedge clk);
      wr_ps2 = 1'b0;
      repeat (100) @(negedge clk);
      din = d3;
      wr_ps2 = 1'b1;
      @(negedge clk);
      wr_ps2 = 1'b0;
      din = 8'($urandom);
      device_frame(12, 1'b1, 1'b0, capt);
      repeat (2 * HALF) @(negedge clk);
      checks++;
      if (capt !== expected_frame(d2)) begin
         errors++;
         $display("[TB] FAIL ignored_request_bits got %011b expected %011b", capt, expected_frame(d2));
      end
      checks++;
      if ((doneCnt - d0) !== 1) begin
         errors++;
         $display("[TB] FAIL ignored_request_done got %0d expected 1", doneCnt - d0);
      end
      test_frame(8'($urandom), 1'b1, 1'b0);
   endtask

   task automatic test_back_to_back();
      int low;
      int w;
      int d0;
      logic [7:0] d;
      logic [10:0] capt;
      d = 8'($urandom);
      d0 = doneCnt;
      send_and_measure(d, low);
      w = 0;
      fork
         device_frame(12, 1'b1, 1'b0, capt);
         begin
            while (!(tx_done_tick === 1'b1 || ack_err === 1'b1 || timeout_tick === 1'b1) && w < 20000) begin
               @(negedge clk);
               w++;
            end
            wr_ps2 = 1'b1;
            din = 8'($urandom);
            @(negedge clk);
            wr_ps2 = 1'b0;
         end
      join
      repeat (5) @(negedge clk);
      checks++;
      if (w >= 20000) begin
         errors++;
         $display("[TB] FAIL b2b_tick_seen waited %0d cycles, required a tick", w);
      end
      checks++;
      if (tx_idle !== 1'b1 || ps2c !== 1'b1) begin
         errors++;
         $display("[TB] FAIL b2b_tick_request got idle=%b ps2c=%b expected 1 1", tx_idle, ps2c);
      end
      checks++;
      if (capt !== expected_frame(d) || (doneCnt - d0) !== 1) begin
         errors++;
         $display("[TB] FAIL b2b_frame got %011b done=%0d expected %011b done=1",
                  capt, doneCnt - d0, expected_frame(d));
      end
      test_frame(8'($urandom), 1'b1, 1'b0);
   endtask

   // Sequence every scenario, then print the summary.
   initial begin
      @(negedge clk);
      test_reset();
      test_frame(8'hED, 1'b1, 1'b0);
      test_parity();
      test_frame(8'hF4, 1'b0, 1'b0);
      test_timeout();
      test_frame(8'hAA, 1'b1, 1'b1);
      test_reset_mid_frame();
      test_back_to_back();
      checks++;
      if (overlapCnt !== 0) begin
         errors++;
         $display("[TB] FAIL tick_exclusive got %0d overlapping cycles expected 0", overlapCnt);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard stop in case the design never releases a wait.
   initial begin
      #800000;
      $display("[TB] FAIL global_timeout got no finish expected finish within 80000 cycles");
      $fatal(1, "[TB] simulation stopped by global guard");
   end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard.
- Implements request-to-send, bit shifting on device-generated clock falling edges, odd parity, stop bit, device ack check and a watchdog.
- Shares the ps2c/ps2d lines with the existing keyboard receive path.
- tx_idle feeds that receiver's rx_en so the receiver ignores the host's own frame.

Parameters:
- INHIBIT_CYC, 10000, clk cycles ps2c is held low for request-to-send (100 us at 100 MHz).
- TIMEOUT_CYC, 2000000, max clk cycles between device clock falling edges before abort (20 ms).
- FILT_LEN, 8, ps2c glitch-filter depth in samples.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- wr_ps2  in  1  start request; accepted only when tx_idle=1.
- din  in  8  command byte, sampled on the accepting cycle.
- ps2c  inout  1  PS/2 clock; driven 0 or high-Z only, never driven 1.
- ps2d  inout  1  PS/2 data; driven 0 or high-Z only, never driven 1.
- tx_idle  out  1  1 when in IDLE.
- tx_done_tick  out  1  one-cycle pulse; frame finished and ack was seen.
- ack_err  out  1  one-cycle pulse; frame finished but ps2d was 1 at the ack edge.
- timeout_tick  out  1  one-cycle pulse; watchdog abort.

Behaviour:
- Reset (async): state=IDLE; both lines high-Z; tx_idle=1; all ticks 0; counters 0.
- Reset mid-frame: both lines released immediately; no tick generated.
- ps2c filter: shift register of FILT_LEN samples. Filtered level goes 1 when all samples are 1 and 0 when all are 0, otherwise holds. fall_edge = filtered 1->0 transition; acted on only in START, DATA, STOP, ACK.
- Data latch on accept: shift register b = {~^din, din}; bit 8 is odd parity.
- IDLE: lines released. On wr_ps2 -> RTS; counter loaded with INHIBIT_CYC-1.
- RTS: ps2c driven 0, ps2d released; counter decrements each cycle. At 0 -> START. ps2c is low exactly INHIBIT_CYC cycles.
- START: ps2d driven 0 (start bit); ps2c released. On fall_edge -> DATA; n=8.
- DATA: ps2d driven 0 if b[0]=0, released if b[0]=1. On fall_edge: b shifts right. If n=0 -> STOP, else n decrements. 9 bits total: data LSB first, then parity.
- STOP: ps2d released (stop=1). On fall_edge -> ACK.
- ACK: ps2d released. On fall_edge sample the synchronized ps2d:
  - 0 -> tx_done_tick=1.
  - 1 -> ack_err=1.
  - Either way -> IDLE next cycle.
- Watchdog: counts in START..ACK; cleared on every fall_edge and on state entry. Reaching TIMEOUT_CYC -> release lines, timeout_tick=1, IDLE.
- Edge cases:
  - wr_ps2 while not idle: ignored; din is not re-sampled.
  - wr_ps2 in the same cycle a tick is asserted: not accepted, because state is not yet IDLE.
  - Ticks are mutually exclusive; exactly one per accepted frame unless rst intervenes.
- ps2d input passes through a 2-flop synchronizer. All outputs are registered.

Test Plan:
- Send 0xED with a bench device model: 40 us clock period, samples ps2d while ps2c high, drives ack low on the 11th falling edge. Required:
  - ps2c held low 10000 cycles.
  - Device captures start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done_tick pulses once; tx_idle returns to 1.
- Send 0x01 (parity 0) and 0xFF (parity 1) -> device captures parity 0 and parity 1 respectively; tx_done_tick each.
- Device model withholds ack (ps2d stays 1 on 11th edge), byte 0xF4 -> ack_err pulses once; no tx_done_tick; state IDLE.
- TIMEOUT_CYC=5000, device stops clocking after 4 bits -> timeout_tick exactly 5000 cycles after last fall_edge; both lines high-Z.
- Inject 3-cycle low glitches on ps2c during DATA -> no extra shifts; 0xAA received intact.
- Assert rst during DATA; pulse wr_ps2 during RTS -> lines released at once, no ticks; second request ignored and a later idle request succeeds.
